// File: rtl/jt51_noise_chk.sv
// jt51_noise_chk: self-synchronising checker for the 17-bit XNOR noise LFSR stream.
// JT51_NOISE_CHK_ERRCNT_EN adds the saturating LOCK error counter (err_cnt tied to 0 otherwise).
module jt51_noise_chk #(
   parameter int LOCK_CNT = 32,
   parameter int LOSS_CNT = 4,
   parameter int ERR_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cen,
   input  logic             base,
   input  logic             din,
   input  logic             clr,
   output logic             locked,
   output logic             err,
   output logic [ERR_W-1:0] err_cnt,
   output logic             expect_bit
);
   localparam logic [1:0] HUNT = 2'd0, VERIFY = 2'd1, LOCK = 2'd2;
   logic [1:0]  state;
   logic [16:0] sr;
   logic [4:0]  fill;
   logic [7:0]  match;
   logic [3:0]  miss;
   logic        step, hit;
   assign step       = cen & base;
   assign expect_bit = ~(sr[16] ^ sr[13]);
   assign hit        = din == expect_bit;
   assign locked     = state == LOCK;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= HUNT;
         sr    <= '0;
         fill  <= '0;
         match <= '0;
         miss  <= '0;
         err   <= 1'b0;
      end else begin
         err <= 1'b0;
         if (step) begin
            // in LOCK the prediction is fed back so a corrupted bit never enters the history
            sr <= {sr[15:0], state == LOCK ? expect_bit : din};
            case (state)
               HUNT:
                  if (fill == 5'd16) begin
                     state <= VERIFY;
                     fill  <= '0;
                     match <= '0;
                  end else fill <= fill + 5'd1;
               VERIFY:
                  if (!hit || &sr) match <= '0;
                  else if (match == 8'(LOCK_CNT - 1)) begin
                     state <= LOCK;
                     match <= '0;
                     miss  <= '0;
                  end else match <= match + 8'd1;
               default:
                  if (hit) miss <= '0;
                  else begin
                     err <= 1'b1;
                     if (miss == 4'(LOSS_CNT - 1)) begin
                        state <= HUNT;
                        fill  <= '0;
                        miss  <= '0;
                     end else miss <= miss + 4'd1;
                  end
            endcase
         end
      end
`ifdef JT51_NOISE_CHK_ERRCNT_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) err_cnt <= '0;
      else if (clr) err_cnt <= '0;
      else if (step && state == LOCK && !hit && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
`else
   logic unused_clr;
   assign unused_clr = clr;
   assign err_cnt    = '0;
`endif
endmodule

// File: tb/tb_jt51_noise_chk.sv
// tb_jt51_noise_chk: scoreboard bench driving an XNOR LFSR stream (seed 14220) into jt51_noise_chk.
module tb_jt51_noise_chk;
   logic       clk = 1'b0, rst_n = 1'b0, cen = 1'b1, base = 1'b0, din = 1'b0, clr = 1'b0;
   logic       locked, err, expect_bit;
   logic [3:0] err_cnt;
   int         n_tests = 0, n_fail = 0;
`ifdef JT51_NOISE_CHK_ERRCNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif
   typedef struct packed {
      logic       l;
      logic       e;
      logic [3:0] c;
      logic       p;
   } exp_t;
   exp_t        q[$];
   logic [16:0] g = 17'd14220;
   logic [3:0]  cnt_exp = '0;
   logic        hold_l = 1'b0;

   jt51_noise_chk #(.ERR_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .base(base), .din(din), .clr(clr),
      .locked(locked), .err(err), .err_cnt(err_cnt), .expect_bit(expect_bit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic d, input logic el, input logic ee, input logic p, input logic c);
      exp_t x;
      if (c) cnt_exp = '0;
      else if (ee && CNT_EN && cnt_exp != 4'hF) cnt_exp = cnt_exp + 4'd1;
      x = '{l: el, e: ee, c: cnt_exp, p: p};
      @(negedge clk);
      din = d; base = 1'b1; clr = c;
      q.push_back(x);
      @(negedge clk);
      base = 1'b0; clr = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic gstep(input logic flip, input logic el, input logic ee, input logic c);
      logic d;
      d = g[0] ^ flip;
      g = {~(g[0] ^ g[3]), g[16:1]};
      step(d, el, ee, g[0], c);
   endtask

   task automatic relock();
      for (int i = 1; i <= 49; i++) gstep(1'b0, i == 49, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst locked", locked, 0);
      chk("rst err", err, 0);
      chk("rst err_cnt", err_cnt, 0);
      cnt_exp = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin : monitor
      exp_t x;
      logic s;
      forever begin
         @(posedge clk);
         s = cen & base & rst_n;
         #1;
         if (!rst_n) hold_l = 1'b0;
         else if (s) begin
            if (q.size() == 0) chk("queue underflow", 1, 0);
            else begin
               x = q.pop_front();
               chk("step locked/err/cnt", {locked, err, err_cnt}, {x.l, x.e, x.c});
               if (x.l) chk("pred next din", expect_bit, x.p);
               hold_l = x.l;
            end
         end else begin
            chk("idle err low", err, 0);
            chk("idle locked hold", locked, hold_l);
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("init locked", locked, 0);
      chk("init err", err, 0);
      chk("init err_cnt", err_cnt, 0);
      rst_n = 1'b1;
      relock();
      repeat (10000) gstep(1'b0, 1'b1, 1'b0, 1'b0);
      gstep(1'b1, 1'b1, 1'b1, 1'b0);
      repeat (7) gstep(1'b0, 1'b1, 1'b0, 1'b0);
      // corrupted bits offered without cen must not be sampled
      @(negedge clk);
      cen = 1'b0; base = 1'b1; din = ~g[0];
      repeat (8) @(negedge clk);
      cen = 1'b1; base = 1'b0;
      repeat (8) gstep(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) gstep(1'b1, i < 3, 1'b1, 1'b0);
      relock();
      repeat (8) gstep(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (12) begin
         gstep(1'b1, 1'b1, 1'b1, 1'b0);
         repeat (7) gstep(1'b0, 1'b1, 1'b0, 1'b0);
      end
      gstep(1'b1, 1'b1, 1'b1, 1'b1);
      repeat (7) gstep(1'b0, 1'b1, 1'b0, 1'b0);
      gstep(1'b1, 1'b1, 1'b1, 1'b0);
      repeat (3) gstep(1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      cnt_exp = '0;
      chk("clr alone", err_cnt, 0);
      repeat (5) gstep(1'b0, 1'b1, 1'b0, 1'b0);
      do_reset();
      relock();
      repeat (5) gstep(1'b0, 1'b1, 1'b0, 1'b0);
      do_reset();
      repeat (500) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      do_reset();
      repeat (500) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      chk("queue drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
